// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte (0xED set-LEDs,
// 0xF4 enable, 0xFF reset, ...) to the keyboard over the shared open-drain
// PS/2 clock/data lines and reports whether the device acknowledged it.
// The scan-code receiver ignores the bus while tx_busy is high.
//
// Frame on the data line, after the start bit: d0..d7, odd parity, stop(1).
// The device clocks the frame; the host changes data just after each falling
// device clock so it is stable at the device's rising-edge sample. The
// eleventh falling edge carries the device ACK (data pulled low).
//
// Parameters
//   P_INHIBIT_CYC  clk cycles the ps2 clock is held low before the data line
//                  is released to the device (inhibit + request-to-send).
//                  Must be >= 2.
//   P_TIMEOUT_CYC  max clk cycles allowed between device clock falls.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   tx_data[7:0] in   command byte, sampled when tx_req is accepted
//   tx_req       in   1-cycle start strobe, accepted only while idle
//   tx_busy      out  high from acceptance through the done/err pulse
//   tx_done      out  1-cycle pulse: frame sent and ACK received
//   tx_err       out  1-cycle pulse: no ACK or timeout
//   ps2_clk_i    in   ps2 clock pad (asynchronous)
//   ps2_dat_i    in   ps2 data pad (asynchronous)
//   ps2_clk_oe   out  1 = pull ps2 clock low, 0 = release
//   ps2_dat_oe   out  1 = pull ps2 data low,  0 = release
// -----------------------------------------------------------------------------
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | lines released, waiting for tx_req
//  INHIBIT   | ps2 clock held low to hold the device off
//  RTS       | start bit driven low while clock still held (one cycle)
//  DATA      | clock released, device clocks out start/data/parity/stop
//  ACK       | stop released, wait for ACK fall, sample data line
//  WAIT_IDLE | ACK seen, wait for both lines back high
//  DONE      | tx_done pulse
//  ERR       | tx_err pulse, lines released
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter logic [24:0] P_INHIBIT_CYC = 25'd5000,
  parameter logic [24:0] P_TIMEOUT_CYC = 25'd750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  idx_q, idx_d;
  logic        line_q, line_d;
  logic [24:0] inh_cnt_q, inh_cnt_d;
  logic [24:0] to_cnt_q, to_cnt_d;

  // Pad synchronisers. Bit 2 of the clock chain is the previous synchronised
  // value, used only for fall detection. Both chains reset to 1 (idle bus).
  logic [2:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;

  logic        clk_s;
  logic        dat_s;
  logic        clk_fall;
  logic        in_watch;
  logic        to_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

  // Timeout only guards the phases where the device owns the clock.
  assign in_watch   = (state_q == S_DATA) || (state_q == S_ACK) ||
                      (state_q == S_WAIT_IDLE);
  assign to_expired = in_watch && (to_cnt_q >= (P_TIMEOUT_CYC - 25'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '1;
      idx_q     <= '0;
      line_q    <= 1'b1;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Saturating up-counter, cleared on every device clock fall and whenever
  // the device is not clocking.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_watch || clk_fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 25'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    line_d    = line_q;
    inh_cnt_d = inh_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (tx_req) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          idx_d     = '0;
          line_d    = 1'b0;
          // INHIBIT lasts P_INHIBIT_CYC-1 cycles; RTS adds the last one so the
          // clock is held low for exactly P_INHIBIT_CYC cycles in total.
          inh_cnt_d = P_INHIBIT_CYC - 25'd2;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          state_d = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q - 25'd1;
        end
      end

      S_RTS: begin
        state_d = S_DATA;
      end

      S_DATA: begin
        if (to_expired) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          line_d  = frame_q[0];
          frame_d = {1'b1, frame_q[9:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (to_expired) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          state_d = dat_s ? S_ERR : S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (to_expired) begin
          state_d = S_ERR;
        end else if (clk_s && dat_s) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // releases both lines immediately.
  assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_dat_oe = ((state_q == S_RTS) || (state_q == S_DATA)) && !line_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = (state_q == S_DONE);
  assign tx_err     = (state_q == S_ERR);

endmodule
